bnn_layer_sequencer: RTL and testbench

//  Bit-serial sequencer for one binarized fully-connected layer of the BNN MLP.
//  - Captures an input vector, a packed weight matrix and packed per-neuron thresholds on a start handshake.
//  - Per neuron: accumulates XNOR matches one input bit per clock, then compares the count against

---
 rtl/bnn_layer_sequencer.sv | 139 +++++++++++++
 tb/tb_bnn_layer_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bnn_layer_sequencer.sv
// Bit-serial sequencer for one binarized fully-connected layer: one XNOR/popcount/compare
// slice is time-shared across all neurons, one input bit per clock.
module bnn_layer_sequencer #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 4,
    parameter int BIAS_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [N_IN-1:0]          in_vec,
    input  logic [N_IN*N_OUT-1:0]    weights,
    input  logic [BIAS_W*N_OUT-1:0]  bias,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [N_OUT-1:0]         result
);

    localparam int AW = $clog2(N_IN + 1);
    localparam int BW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int NW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int CW = (AW > BIAS_W) ? AW : BIAS_W;

    // Handshake: start is taken on a rising edge where start=1 and ready=1; operands are
    // sampled only then. done is a one-cycle pulse; result changes on the edge ending it.
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_CMP, S_DONE} state_t;

    state_t                    state, state_nx;
    logic [N_IN-1:0]           in_r;
    logic [N_IN*N_OUT-1:0]     w_r;
    logic [BIAS_W*N_OUT-1:0]   bias_r;
    logic [AW-1:0]             acc;
    logic [BW-1:0]             bit_idx;
    logic [NW-1:0]             neuron_idx;
    logic [N_OUT-1:0]          shadow;

    logic [N_IN-1:0]           w_row;
    logic [BIAS_W-1:0]         bias_sel;
    logic                      match;
    logic                      cmp_bit;
    logic                      bit_last;
    logic                      neuron_last;

    always_comb begin
        w_row       = w_r[neuron_idx*N_IN +: N_IN];
        bias_sel    = bias_r[neuron_idx*BIAS_W +: BIAS_W];
        match       = ~(in_r[bit_idx] ^ w_row[bit_idx]);
        // Both sides zero-extended so an oversized threshold can never be met.
        cmp_bit     = (CW'(acc) >= CW'(bias_sel));
        bit_last    = (bit_idx == BW'(N_IN - 1));
        neuron_last = (neuron_idx == NW'(N_OUT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_nx = S_ACCUM;
            end
            S_ACCUM: begin
                busy = 1'b1;
                if (abort)         state_nx = S_IDLE;
                else if (bit_last) state_nx = S_CMP;
            end
            S_CMP: begin
                busy = 1'b1;
                if (abort)            state_nx = S_IDLE;
                else if (neuron_last) state_nx = S_DONE;
                else                  state_nx = S_ACCUM;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_r       <= '0;
            w_r        <= '0;
            bias_r     <= '0;
            acc        <= '0;
            bit_idx    <= '0;
            neuron_idx <= '0;
            shadow     <= '0;
            result     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        in_r       <= in_vec;
                        w_r        <= weights;
                        bias_r     <= bias;
                        acc        <= '0;
                        bit_idx    <= '0;
                        neuron_idx <= '0;
                        shadow     <= '0;
                    end
                end
                S_ACCUM: begin
                    if (abort) begin
                        shadow <= '0;
                    end else begin
                        acc     <= acc + AW'(match);
                        bit_idx <= bit_last ? '0 : bit_idx + 1'b1;
                    end
                end
                S_CMP: begin
                    if (abort) begin
                        shadow <= '0;
                    end else begin
                        shadow[neuron_idx] <= cmp_bit;
                        acc                <= '0;
                        bit_idx            <= '0;
                        if (!neuron_last) neuron_idx <= neuron_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    result <= shadow;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Directed bench for bnn_layer_sequencer: a cycle-timeline model of the layer run is
// compared against the DUT on every falling edge, plus literal expectations per case.
module tb_bnn_layer_sequencer;

    localparam int N_IN   = 4;
    localparam int N_OUT  = 4;
    localparam int BIAS_W = 4;
    localparam int RUN_CYCLES = N_OUT * (N_IN + 1) + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  in_vec = '0;
    logic [15:0] weights = '0;
    logic [15:0] bias = '0;
    logic        ready, busy, done;
    logic [3:0]  result;

    int total = 0;
    int bad = 0;
    bit cmp_en = 1'b0;

    bnn_layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .BIAS_W(BIAS_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_vec(in_vec), .weights(weights), .bias(bias),
        .ready(ready), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Layer function straight from the definition: count input/weight agreements per neuron.
    function automatic logic [3:0] layer_fn(input logic [3:0] iv, input logic [15:0] w,
                                            input logic [15:0] b);
        logic [3:0] r;
        int cnt;
        r = '0;
        for (int j = 0; j < N_OUT; j++) begin
            cnt = 0;
            for (int i = 0; i < N_IN; i++)
                if (iv[i] == w[j*N_IN+i]) cnt++;
            r[j] = (cnt >= int'(b[j*BIAS_W +: BIAS_W]));
        end
        return r;
    endfunction

    // Timeline model: rem = cycles left until ready returns (1 means the done cycle).
    int         rem = 0;
    logic [3:0] pend = '0;
    logic [3:0] exp_result = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rem = 0;
            pend = '0;
            exp_result = '0;
        end else if (rem == 0) begin
            if (start) begin
                rem = RUN_CYCLES;
                pend = layer_fn(in_vec, weights, bias);
            end
        end else if (rem == 1) begin
            exp_result = pend;
            rem = 0;
        end else if (abort) begin
            rem = 0;
        end else begin
            rem--;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ready", ready, rem == 0);
            check("busy", busy, rem > 1);
            check("done", done, rem == 1);
            check("result", result, exp_result);
        end
    end

    task automatic set_ops(input logic [3:0] iv, input logic [15:0] w, input logic [15:0] b);
        in_vec = iv;
        weights = w;
        bias = b;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!done && cnt < 60);
    endtask

    task automatic run_case(input string name, input logic [3:0] iv, input logic [15:0] w,
                            input logic [15:0] b, input logic [3:0] exp_r);
        int cnt;
        @(negedge clk);
        set_ops(iv, w, b);
        pulse_start();
        wait_done(cnt);
        check({name, "_latency"}, cnt, RUN_CYCLES);
        @(negedge clk);
        check({name, "_result"}, result, exp_r);
    endtask

    initial begin
        int cnt;
        #1;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("model_pin1", layer_fn(4'b1001, 16'hFFFF, 16'hB3C7), 4'b0000);
        check("model_pin2", layer_fn(4'b1001, 16'hFFFF, 16'h3322), 4'b0011);
        check("model_pin3", layer_fn(4'b1001, 16'h6666, 16'h0000), 4'b1111);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;

        run_case("c1", 4'b1001, 16'hFFFF, 16'hB3C7, 4'b0000);
        run_case("c2a", 4'b1001, 16'hFFFF, 16'h3322, 4'b0011);

        // Abort during the done cycle must not stop the result update.
        @(negedge clk);
        set_ops(4'b1001, 16'hFFFF, 16'h2120);
        pulse_start();
        wait_done(cnt);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("c2b_result", result, 4'b1111);

        run_case("c3a", 4'b1001, 16'h6666, 16'h0000, 4'b1111);
        run_case("c3b", 4'b1001, 16'h6666, 16'h1111, 4'b0000);

        // Retrigger mid-run with new operands is ignored; start held over done is taken once ready.
        @(negedge clk);
        set_ops(4'b1001, 16'hFFFF, 16'hB3C7);
        pulse_start();
        repeat (5) @(negedge clk);
        set_ops(4'b1001, 16'h6666, 16'h0000);
        pulse_start();
        wait_done(cnt);
        start = 1'b1;
        @(posedge clk);
        #1 check("c4_held_start_ignored_in_done", ready, 1);
        @(posedge clk);
        #1 start = 1'b0;
        check("c4_accepted_after_done", busy, 1);
        check("c4_result_first", result, 4'b0000);
        wait_done(cnt);
        check("c4b_latency", cnt, RUN_CYCLES);
        @(negedge clk);
        check("c4b_result", result, 4'b1111);

        // Abort mid-run; start+abort together in IDLE still starts.
        run_case("c5a", 4'b1001, 16'hFFFF, 16'h3322, 4'b0011);
        @(negedge clk);
        set_ops(4'b1001, 16'hFFFF, 16'hB3C7);
        pulse_start();
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("c5_abort_ready", ready, 1);
        check("c5_abort_done", done, 0);
        check("c5_abort_result", result, 4'b0011);
        repeat (25) @(negedge clk);
        check("c5_no_late_done_result", result, 4'b0011);
        abort = 1'b1;
        set_ops(4'b1001, 16'hFFFF, 16'hB3C7);
        pulse_start();
        abort = 1'b0;
        wait_done(cnt);
        check("c5b_latency", cnt, RUN_CYCLES);
        @(negedge clk);
        check("c5b_result", result, 4'b0000);

        // Asynchronous reset mid-run, after a nonzero result.
        run_case("c6pre", 4'b1001, 16'h6666, 16'h0000, 4'b1111);
        @(negedge clk);
        set_ops(4'b1001, 16'hFFFF, 16'h3322);
        pulse_start();
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("c6_rst_ready", ready, 1);
        check("c6_rst_busy", busy, 0);
        check("c6_rst_done", done, 0);
        check("c6_rst_result", result, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        run_case("c6post", 4'b1001, 16'hFFFF, 16'h3322, 4'b0011);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
